gost34_12_2015_sbox_pipe: RTL and testbench

GOST34_12_2015_SBOX_PIPE -- requirements
Module: gost34_12_2015_sbox_pipe

---
 rtl/gost34_12_2015_sbox_pipe.sv | 170 +++++++++++++++++
 tb/tb_gost34_12_2015_sbox_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gost34_12_2015_sbox_pipe.sv
// rtl/gost34_12_2015_sbox_pipe.sv - GOST R 34.12-2015 byte substitution engine, LANES bytes per cycle
//
// Substitutes all 16 bytes of a 128-bit block through a programmable 256x8
// table, LANES bytes per cycle over BEATS = 16/LANES cycles.
// Optional inverse table: define GOST_SBOX_INV_EN.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cfg_we/cfg_inv/cfg_addr/cfg_data    table write (accepted only while cfg_ready)
//   cfg_ready                           high in IDLE
//   in_valid/in_ready/in_mode/in_data   block input handshake, mode 1 = inverse
//   out_valid/out_ready/out_data        result handshake, held stable in HOLD
module gost34_12_2015_sbox_pipe #(
  parameter  int LANES = 4,
  localparam int BEATS = 16 / LANES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic         cfg_inv,
  input  logic [7:0]   cfg_addr,
  input  logic [7:0]   cfg_data,
  output logic         cfg_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

  state_t         state_q, state_n;
  logic [CW-1:0]  cnt_q;
  logic [127:0]   data_q, sub_data;
  logic [7:0]     fwd_tab [256];
  logic           accept, cfg_ok, wr_fwd, wr_inv, last_beat, use_inv;
  logic [7:0]     old_val;

  // A write accepted in the same cycle as a block must not affect that block.
  // Only one such write can exist per block (writes are dropped while busy),
  // so the overwritten entry is kept aside and substituted back on a match.
  logic           byp_vld_q, byp_inv_q;
  logic [7:0]     byp_addr_q, byp_old_q;

  int             idx;
  logic [7:0]     lb, lv;

  assign cfg_ok    = cfg_we & cfg_ready;
  assign accept    = in_valid & in_ready;
  assign last_beat = (cnt_q == CW'(BEATS - 1));
  assign out_data  = data_q;

`ifdef GOST_SBOX_INV_EN
  logic [7:0] inv_tab [256];
  logic       mode_q;

  assign wr_fwd  = cfg_ok & ~cfg_inv;
  assign wr_inv  = cfg_ok & cfg_inv;
  assign use_inv = mode_q;
  assign old_val = cfg_inv ? inv_tab[cfg_addr] : fwd_tab[cfg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) inv_tab[i] <= 8'(i);
    end else if (wr_inv) begin
      inv_tab[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mode_q <= 1'b0;
    else if (accept) mode_q <= in_mode;
  end
`else
  logic unused_mode;

  assign unused_mode = in_mode;
  assign wr_fwd      = cfg_ok & ~cfg_inv;
  assign wr_inv      = 1'b0;
  assign use_inv     = 1'b0;
  assign old_val     = fwd_tab[cfg_addr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) fwd_tab[i] <= 8'(i);
    end else if (wr_fwd) begin
      fwd_tab[cfg_addr] <= cfg_data;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept)    state_n = SUB;
      SUB:     if (last_beat) state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
      end
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Lanes of the current beat; byte k sits at data_q[127-8k -: 8].
  always_comb begin
    sub_data = data_q;
    idx      = 0;
    lb       = 8'h00;
    lv       = 8'h00;
    for (int j = 0; j < LANES; j++) begin
      idx = int'(cnt_q) * LANES + j;
      lb  = data_q[8*(15-idx) +: 8];
`ifdef GOST_SBOX_INV_EN
      lv  = use_inv ? inv_tab[lb] : fwd_tab[lb];
`else
      lv  = fwd_tab[lb];
`endif
      if (byp_vld_q && (byp_inv_q == use_inv) && (byp_addr_q == lb))
        lv = byp_old_q;
      sub_data[8*(15-idx) +: 8] = lv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      data_q     <= '0;
      byp_vld_q  <= 1'b0;
      byp_inv_q  <= 1'b0;
      byp_addr_q <= 8'h00;
      byp_old_q  <= 8'h00;
    end else if (accept) begin
      cnt_q      <= '0;
      data_q     <= in_data;
      byp_vld_q  <= wr_fwd | wr_inv;
      byp_inv_q  <= cfg_inv;
      byp_addr_q <= cfg_addr;
      byp_old_q  <= old_val;
    end else if (state_q == SUB) begin
      data_q <= sub_data;
      if (!last_beat) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_gost34_12_2015_sbox_pipe.sv
// tb/tb_gost34_12_2015_sbox_pipe.sv - directed bench for gost34_12_2015_sbox_pipe at LANES 1, 4 and 16
module tb_gost34_12_2015_sbox_pipe;

  localparam logic [127:0] ID_VEC = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] PI_IN  = {8'h00, 8'h01, {14{8'hFF}}};
  localparam logic [127:0] PI_OUT = {8'hFC, 8'hEE, {14{8'hB6}}};
  localparam logic [127:0] ALL_FC = {16{8'hFC}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   cfg_we, in_valid, out_ready;
  logic         cfg_inv, in_mode;
  logic [7:0]   cfg_addr, cfg_data;
  logic [127:0] in_data;
  logic [2:0]   cfg_ready, in_ready, out_valid;
  logic [127:0] out_data [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_lat [3] = '{17, 5, 2};

  logic [7:0] pi_tab [256] = '{
    8'hFC,8'hEE,8'hDD,8'h11,8'hCF,8'h6E,8'h31,8'h16,8'hFB,8'hC4,8'hFA,8'hDA,8'h23,8'hC5,8'h04,8'h4D,
    8'hE9,8'h77,8'hF0,8'hDB,8'h93,8'h2E,8'h99,8'hBA,8'h17,8'h36,8'hF1,8'hBB,8'h14,8'hCD,8'h5F,8'hC1,
    8'hF9,8'h18,8'h65,8'h5A,8'hE2,8'h5C,8'hEF,8'h21,8'h81,8'h1C,8'h3C,8'h42,8'h8B,8'h01,8'h8E,8'h4F,
    8'h05,8'h84,8'h02,8'hAE,8'hE3,8'h6A,8'h8F,8'hA0,8'h06,8'h0B,8'hED,8'h98,8'h7F,8'hD4,8'hD3,8'h1F,
    8'hEB,8'h34,8'h2C,8'h51,8'hEA,8'hC8,8'h48,8'hAB,8'hF2,8'h2A,8'h68,8'hA2,8'hFD,8'h3A,8'hCE,8'hCC,
    8'hB5,8'h70,8'h0E,8'h56,8'h08,8'h0C,8'h76,8'h12,8'hBF,8'h72,8'h13,8'h47,8'h9C,8'hB7,8'h5D,8'h87,
    8'h15,8'hA1,8'h96,8'h29,8'h10,8'h7B,8'h9A,8'hC7,8'hF3,8'h91,8'h78,8'h6F,8'h9D,8'h9E,8'hB2,8'hB1,
    8'h32,8'h75,8'h19,8'h3D,8'hFF,8'h35,8'h8A,8'h7E,8'h6D,8'h54,8'hC6,8'h80,8'hC3,8'hBD,8'h0D,8'h57,
    8'hDF,8'hF5,8'h24,8'hA9,8'h3E,8'hA8,8'h43,8'hC9,8'hD7,8'h79,8'hD6,8'hF6,8'h7C,8'h22,8'hB9,8'h03,
    8'hE0,8'h0F,8'hEC,8'hDE,8'h7A,8'h94,8'hB0,8'hBC,8'hDC,8'hE8,8'h28,8'h50,8'h4E,8'h33,8'h0A,8'h4A,
    8'hA7,8'h97,8'h60,8'h73,8'h1E,8'h00,8'h62,8'h44,8'h1A,8'hB8,8'h38,8'h82,8'h64,8'h9F,8'h26,8'h41,
    8'hAD,8'h45,8'h46,8'h92,8'h27,8'h5E,8'h55,8'h2F,8'h8C,8'hA3,8'hA5,8'h7D,8'h69,8'hD5,8'h95,8'h3B,
    8'h07,8'h58,8'hB3,8'h40,8'h86,8'hAC,8'h1D,8'hF7,8'h30,8'h37,8'h6B,8'hE4,8'h88,8'hD9,8'hE7,8'h89,
    8'hE1,8'h1B,8'h83,8'h49,8'h4C,8'h3F,8'hF8,8'hFE,8'h8D,8'h53,8'hAA,8'h90,8'hCA,8'hD8,8'h85,8'h61,
    8'h20,8'h71,8'h67,8'hA4,8'h2D,8'h2B,8'h09,8'h5B,8'hCB,8'h9B,8'h25,8'hD0,8'hBE,8'hE5,8'h6C,8'h52,
    8'h59,8'hA6,8'h74,8'hD2,8'hE6,8'hF4,8'hB4,8'hC0,8'hD1,8'h66,8'hAF,8'hC2,8'h39,8'h4B,8'h63,8'hB6
  };
  logic [7:0] pi_inv [256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gost34_12_2015_sbox_pipe #(.LANES(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we[g]),
      .cfg_inv   (cfg_inv),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_tab(input logic [2:0] m, input logic inv, input logic [7:0] a, input logic [7:0] v);
    cfg_we = m; cfg_inv = inv; cfg_addr = a; cfg_data = v;
    @(posedge clk); #1;
    cfg_we = 3'b000;
  endtask

  task automatic start_blk(input int d, input logic [127:0] din, input logic md, output int acc);
    int n = 0;
    in_data = din; in_mode = md; in_valid[d] = 1'b1;
    @(negedge clk);
    while (!in_ready[d] && n < 50) begin @(negedge clk); n++; end
    total++;
    if (in_ready[d] !== 1'b1) begin
      bad++; $display("FAIL start_timeout dut%0d in_ready=%b want=1", d, in_ready[d]);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    acc = cyc;
  endtask

  task automatic finish_blk(input int d, input int acc, output logic [127:0] dout, output int lat);
    int n = 0;
    @(negedge clk);
    while (!out_valid[d] && n < 60) begin @(negedge clk); n++; end
    total++;
    if (out_valid[d] !== 1'b1) begin
      bad++; $display("FAIL out_timeout dut%0d out_valid=%b want=1", d, out_valid[d]);
    end
    lat  = cyc + 1 - acc;
    dout = out_data[d];
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_we = '0; in_valid = '0; out_ready = '0;
    cfg_inv = 1'b0; cfg_addr = '0; cfg_data = '0; in_mode = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total += 4;
      if (in_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_in_ready dut%0d got=%b want=1", d, in_ready[d]); end
      if (cfg_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready dut%0d got=%b want=1", d, cfg_ready[d]); end
      if (out_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d got=%b want=0", d, out_valid[d]); end
      if (out_data[d] !== 128'h0) begin bad++; $display("FAIL reset_out_data dut%0d got=%h want=0", d, out_data[d]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity;
    int acc, lat;
    logic [127:0] got;
    for (int d = 0; d < 3; d++) begin
      start_blk(d, ID_VEC, 1'b0, acc);
      finish_blk(d, acc, got, lat);
      total += 2;
      if (got !== ID_VEC) begin bad++; $display("FAIL identity_data dut%0d got=%h want=%h", d, got, ID_VEC); end
      if (lat !== exp_lat[d]) begin bad++; $display("FAIL identity_latency dut%0d got=%0d want=%0d", d, lat, exp_lat[d]); end
    end
  endtask

  task automatic test_back_to_back;
    int acc0, acc1, lat;
    logic [127:0] got;
    start_blk(1, ID_VEC, 1'b0, acc0);
    finish_blk(1, acc0, got, lat);
    total++;
    if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b want=1", in_ready[1]); end
    start_blk(1, PI_IN, 1'b0, acc1);
    finish_blk(1, acc1, got, lat);
    total += 2;
    if (acc1 - acc0 !== 6) begin bad++; $display("FAIL b2b_period got=%0d want=6", acc1 - acc0); end
    if (got !== PI_IN) begin bad++; $display("FAIL b2b_data got=%h want=%h", got, PI_IN); end
  endtask

  task automatic test_pi_table;
    int acc, lat;
    logic [127:0] got;
    for (int i = 0; i < 256; i++) write_tab(3'b111, 1'b0, 8'(i), pi_tab[i]);
    for (int d = 0; d < 3; d++) begin
      start_blk(d, PI_IN, 1'b0, acc);
      finish_blk(d, acc, got, lat);
      total += 2;
      if (got !== PI_OUT) begin bad++; $display("FAIL pi_data dut%0d got=%h want=%h", d, got, PI_OUT); end
      if (lat !== exp_lat[d]) begin bad++; $display("FAIL pi_latency dut%0d got=%0d want=%0d", d, lat, exp_lat[d]); end
    end
`ifdef GOST_SBOX_INV_EN
    for (int i = 0; i < 256; i++) write_tab(3'b111, 1'b1, 8'(i), pi_inv[i]);
    for (int d = 0; d < 3; d++) begin
      start_blk(d, ALL_FC, 1'b1, acc);
      finish_blk(d, acc, got, lat);
      total++;
      if (got !== 128'h0) begin bad++; $display("FAIL pi_inv_data dut%0d got=%h want=0", d, got); end
    end
`endif
  endtask

  task automatic test_hold_stall;
    int acc, lat, n;
    logic [127:0] got;
    start_blk(1, PI_IN, 1'b0, acc);
    total++;
    if (cfg_ready[1] !== 1'b0) begin bad++; $display("FAIL sub_cfg_ready got=%b want=0", cfg_ready[1]); end
    write_tab(3'b010, 1'b0, 8'h00, 8'h11);
    n = 0;
    @(negedge clk);
    while (!out_valid[1] && n < 60) begin @(negedge clk); n++; end
    for (int k = 0; k < 10; k++) begin
      total += 3;
      if (out_valid[1] !== 1'b1) begin bad++; $display("FAIL stall_out_valid cyc%0d got=%b want=1", k, out_valid[1]); end
      if (out_data[1] !== PI_OUT) begin bad++; $display("FAIL stall_out_data cyc%0d got=%h want=%h", k, out_data[1], PI_OUT); end
      if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc%0d got=%b want=0", k, in_ready[1]); end
      @(negedge clk);
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    start_blk(1, PI_IN, 1'b0, acc);
    finish_blk(1, acc, got, lat);
    total++;
    if (got !== PI_OUT) begin bad++; $display("FAIL busy_write_dropped got=%h want=%h", got, PI_OUT); end
  endtask

  task automatic test_same_cycle_write;
    int acc, lat;
    logic [127:0] got;
    cfg_we = 3'b010; cfg_inv = 1'b0; cfg_addr = 8'h00; cfg_data = 8'h42;
    in_data = '0; in_mode = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    cfg_we = 3'b000; in_valid[1] = 1'b0;
    acc = cyc;
    finish_blk(1, acc, got, lat);
    total++;
    if (got !== {16{8'hFC}}) begin bad++; $display("FAIL same_cycle_old_table got=%h want=%h", got, {16{8'hFC}}); end
    start_blk(1, 128'h0, 1'b0, acc);
    finish_blk(1, acc, got, lat);
    total++;
    if (got !== {16{8'h42}}) begin bad++; $display("FAIL same_cycle_new_table got=%h want=%h", got, {16{8'h42}}); end
    write_tab(3'b010, 1'b0, 8'h00, 8'hFC);
  endtask

  task automatic test_reset_mid_sub;
    int acc, lat;
    logic [127:0] got;
    start_blk(1, 128'h0, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total += 2;
    if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b want=0", out_valid[1]); end
    if (out_data[1] !== 128'h0) begin bad++; $display("FAIL midreset_out_data got=%h want=0", out_data[1]); end
    @(posedge clk); #1 rst_n = 1'b1;
    total++;
    if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%b want=1", in_ready[1]); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL midreset_no_output cyc%0d got=%b want=0", k, out_valid[1]); end
    end
    @(posedge clk); #1;
    start_blk(1, 128'h0, 1'b0, acc);
    finish_blk(1, acc, got, lat);
    total++;
    if (got !== 128'h0) begin bad++; $display("FAIL midreset_identity got=%h want=0", got); end
  endtask

  task automatic test_inv_select;
    int acc, lat;
    logic [127:0] got, want;
`ifdef GOST_SBOX_INV_EN
    want = 128'h0;
`else
    want = ALL_FC;
`endif
    write_tab(3'b010, 1'b1, 8'hFC, 8'h00);
    start_blk(1, ALL_FC, 1'b1, acc);
    finish_blk(1, acc, got, lat);
    total++;
    if (got !== want) begin bad++; $display("FAIL inv_mode1 got=%h want=%h", got, want); end
    start_blk(1, ALL_FC, 1'b0, acc);
    finish_blk(1, acc, got, lat);
    total++;
    if (got !== ALL_FC) begin bad++; $display("FAIL inv_fwd_untouched got=%h want=%h", got, ALL_FC); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pi_inv[pi_tab[i]] = 8'(i);
    test_reset;
    test_identity;
    test_back_to_back;
    test_pi_table;
    test_hold_stall;
    test_same_cycle_write;
    test_reset_mid_sub;
    test_inv_select;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
